clk_div_frac_multi: RTL and testbench
=====================================

Name: clk_div_frac_multi

Overview:
- Synthesisable multi-channel clock generator, successor to the behavioural single-output PLL model.
- Derives NUM_CH independent output clocks from one system clock. Each channel has its own integer plus fractional divisor (dual-modulus, accumulator-based) and a per-channel lock flag.
- Sits beside the PLL. Runtime reconfiguration is glitch-free and takes effect only at a period boundary.

Parameters:
NUM_CH, 4, number of output channels (1..16)
DIV_WIDTH, 12, integer divisor width
FRAC_WIDTH, 8, fractional divisor width; average divisor = div_int + div_frac/2^FRAC_WIDTH

Ports:
clk_i  input  1  system clock
srst_i  input  1  synchronous reset, active-high
cfg_valid_i  input  1  config request valid
cfg_ready_o  output  1  config accept ready
cfg_ch_i  input  $clog2(NUM_CH) (min 1)  target channel
cfg_en_i  input  1  channel enable
cfg_div_int_i  input  DIV_WIDTH  integer divisor
cfg_div_frac_i  input  FRAC_WIDTH  fractional divisor
cfg_err_o  output  1  one-cycle pulse on rejected request
clk_o  output  NUM_CH  generated clocks (registered)
locked_o  output  NUM_CH  per-channel lock

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. srst_i sampled on the rising edge of clk_i.
- Reset values: clk_o=0, locked_o=0, cfg_err_o=0, cfg_ready_o=1. All channels disabled; pending=0; count=0; acc=0; div_int=2; div_frac=0.
- Per-channel state: active {en, int, frac}; shadow {en, int, frac}; pending bit; count; acc (FRAC_WIDTH); period length P (DIV_WIDTH+1 bits).
- Handshake:
  - cfg_ready_o = ~pending[cfg_ch_i] when cfg_ch_i < NUM_CH, else 1. It depends combinationally on cfg_ch_i.
  - A request is accepted on an edge with cfg_valid_i & cfg_ready_o.
  - On acceptance: shadow is loaded, pending is set, locked_o[ch] is cleared.
- Rejection: the request is dropped, cfg_err_o=1 for the next cycle, and no state changes, when either:
  - cfg_ch_i >= NUM_CH, or
  - cfg_en_i=1 with cfg_div_int_i < 2.
- Disable request: cfg_en_i=0 is always legal; the divisor fields are ignored.
- Period boundary: count == P-1 on an enabled channel, or any edge on a disabled channel.
- Apply (at a boundary with pending=1):
  - Active is loaded from shadow; pending cleared; acc starts from 0.
  - A disabled channel applies on the edge after acceptance.
  - An enabled channel finishes its current period first, so no runt or stretched pulse.
- Fractional step (each boundary of an enabled channel):
  - {carry, acc} <= acc_base + frac, where acc_base = 0 on apply, else acc.
  - Next P = int + carry; count <= 0.
- Otherwise an enabled channel does count <= count+1.
- Output waveform: clk_o[ch] = 1 while count < P - floor(P/2), else 0.
  - Even P gives 50% duty.
  - Odd P has the high phase one cycle longer.
- First high cycle: clk_o[ch] rises on the apply edge of an enable.
- Disabled channel: clk_o[ch]=0, count=0, acc=0, locked_o[ch]=0.
  - Disabling takes effect at the current period end, so the last pulse completes.
- Lock: locked_o[ch] is set at the first boundary after an apply that enabled ch, i.e. after one complete period with the new config. It stays set until the next acceptance for ch, a disable, or reset.
- Channels are fully independent. Simultaneous boundaries on multiple channels need no arbitration.
- Acceptance and apply for the same channel cannot coincide, because ready is low while pending.
- Reset mid-operation: all state returns to reset values on that edge, including discarding pending updates. clk_o drops to 0 on the next cycle.
- Latency, from acceptance edge to clk_o rising:
  - disabled channel: 1 cycle;
  - enabled channel: remaining cycles of the current period + 1.

Test Plan:
- Reset: hold srst_i 3 cycles with random cfg traffic -> clk_o=0, locked_o=0, cfg_ready_o=1, cfg_err_o=0 throughout.
- Integer divide:
  - ch0 en, int=4, frac=0 -> rises 1 cycle after accept; period 4, high 2/low 2; locked_o[0] set 4 cycles after first rise.
  - ch1 int=5 -> high 3/low 2.
- Fractional: ch2 int=3, frac=128 (FRAC_WIDTH=8) -> periods alternate 3,4; 256 periods span exactly 896 clk_i cycles; mean deviation 0%.
- Glitch-free reconfig: ch0 running int=10; request int=4 at count=2 -> cfg_ready_o low for ch0 until boundary; current 10-cycle period completes; next period 4; locked_o[0] clears at accept and re-sets after one 4-cycle period; no pulse shorter than 2 cycles.
- Rejection:
  - int=1 en=1 -> cfg_err_o pulse 1 cycle, ch unchanged, locked unchanged.
  - cfg_ch_i=NUM_CH -> same error pulse, cfg_ready_o=1.
- Disable and reset mid-run:
  - disable ch0 mid-period -> last period completes, then clk_o[0]=0, locked_o[0]=0.
  - assert srst_i with pending update on ch3 -> pending discarded; after release, ch3 stays disabled.

Source files
------------

// File: rtl/clk_div_frac_multi_if.sv
// Configuration and output bundle of the multi-channel fractional clock divider.
// Master drives configuration requests; slave is the divider.
interface clk_div_frac_multi_if #(
  parameter int NUM_CH     = 4,
  parameter int DIV_WIDTH  = 12,
  parameter int FRAC_WIDTH = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                  cfg_valid_i;
  logic                  cfg_ready_o;
  logic [CH_W-1:0]       cfg_ch_i;
  logic                  cfg_en_i;
  logic [DIV_WIDTH-1:0]  cfg_div_int_i;
  logic [FRAC_WIDTH-1:0] cfg_div_frac_i;
  logic                  cfg_err_o;
  logic [NUM_CH-1:0]     clk_o;
  logic [NUM_CH-1:0]     locked_o;

  modport master (
    output cfg_valid_i, cfg_ch_i, cfg_en_i, cfg_div_int_i, cfg_div_frac_i,
    input  cfg_ready_o, cfg_err_o, clk_o, locked_o
  );

  modport slave (
    input  cfg_valid_i, cfg_ch_i, cfg_en_i, cfg_div_int_i, cfg_div_frac_i,
    output cfg_ready_o, cfg_err_o, clk_o, locked_o
  );
endinterface

// File: rtl/clk_div_frac_multi.sv
// Multi-channel dual-modulus clock divider: each channel averages div_int + div_frac/2^FRAC_WIDTH
// system cycles per output period; new settings are staged in a shadow and applied at a period end.
module clk_div_frac_multi #(
  parameter int NUM_CH     = 4,
  parameter int DIV_WIDTH  = 12,
  parameter int FRAC_WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               srst_i,
  clk_div_frac_multi_if.slave bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW   = DIV_WIDTH + 1;
  localparam logic [CH_W:0] CH_LIMIT = (CH_W + 1)'(NUM_CH);

  logic              ch_oob;
  logic              sel_pending;
  logic              bad_req;
  logic              accept;
  logic              reject;
  logic              err_q;
  logic [NUM_CH-1:0] pending_vec;

  always_comb begin
    sel_pending = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.cfg_ch_i == CH_W'(i)) sel_pending = pending_vec[i];
    end
  end

  // Ready is combinational on cfg_ch_i: a channel refuses new settings while one is still staged.
  assign ch_oob          = {1'b0, bus.cfg_ch_i} >= CH_LIMIT;
  assign bad_req         = ch_oob | (bus.cfg_en_i & (bus.cfg_div_int_i < DIV_WIDTH'(2)));
  assign bus.cfg_ready_o = ch_oob | ~sel_pending;
  assign accept          = bus.cfg_valid_i & bus.cfg_ready_o & ~bad_req;
  assign reject          = bus.cfg_valid_i & bus.cfg_ready_o & bad_req;
  assign bus.cfg_err_o   = err_q;

  always_ff @(posedge clk_i) begin
    if (srst_i) err_q <= 1'b0;
    else        err_q <= reject;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic                  act_en, sh_en, pending, arm, clk_q, locked_q;
    logic [DIV_WIDTH-1:0]  act_int, sh_int;
    logic [FRAC_WIDTH-1:0] act_frac, sh_frac, acc;
    logic [PW-1:0]         count, period, p_next, count_inc, hi_len;
    logic [FRAC_WIDTH:0]   frac_sum;
    logic                  boundary, apply, hit;

    always_comb begin
      hit       = accept & (bus.cfg_ch_i == CH_W'(g));
      boundary  = ~act_en | (count == period - PW'(1));
      apply     = boundary & pending;
      frac_sum  = apply ? {1'b0, sh_frac} : ({1'b0, acc} + {1'b0, act_frac});
      p_next    = (apply ? {1'b0, sh_int} : {1'b0, act_int}) + PW'(frac_sum[FRAC_WIDTH]);
      count_inc = count + PW'(1);
      hi_len    = period - (period >> 1);
    end

    always_ff @(posedge clk_i) begin
      if (srst_i) begin
        act_en   <= 1'b0;
        act_int  <= DIV_WIDTH'(2);
        act_frac <= '0;
        sh_en    <= 1'b0;
        sh_int   <= DIV_WIDTH'(2);
        sh_frac  <= '0;
        pending  <= 1'b0;
        arm      <= 1'b0;
        count    <= '0;
        period   <= PW'(2);
        acc      <= '0;
        clk_q    <= 1'b0;
        locked_q <= 1'b0;
      end else begin
        if (apply) begin
          pending  <= 1'b0;
          act_en   <= sh_en;
          act_int  <= sh_int;
          act_frac <= sh_frac;
          count    <= '0;
          if (sh_en) begin
            acc    <= frac_sum[FRAC_WIDTH-1:0];
            period <= p_next;
            clk_q  <= 1'b1;
            arm    <= 1'b1;
          end else begin
            acc      <= '0;
            clk_q    <= 1'b0;
            locked_q <= 1'b0;
            arm      <= 1'b0;
          end
        end else if (act_en) begin
          if (boundary) begin
            count  <= '0;
            acc    <= frac_sum[FRAC_WIDTH-1:0];
            period <= p_next;
            clk_q  <= 1'b1;
            if (arm) begin
              locked_q <= 1'b1;
              arm      <= 1'b0;
            end
          end else begin
            count <= count_inc;
            clk_q <= (count_inc < hi_len);
          end
        end
        // NOTE: this sits after the boundary logic on purpose; with non-blocking
        // assignments the last write wins, so an acceptance on the same edge as a
        // period end leaves locked_q cleared.
        if (hit) begin
          sh_en    <= bus.cfg_en_i;
          pending  <= 1'b1;
          locked_q <= 1'b0;
          if (bus.cfg_en_i) begin
            sh_int  <= bus.cfg_div_int_i;
            sh_frac <= bus.cfg_div_frac_i;
          end
        end
      end
    end

    assign pending_vec[g]  = pending;
    assign bus.clk_o[g]    = clk_q;
    assign bus.locked_o[g] = locked_q;
  end

endmodule

// File: tb/tb_clk_div_frac_multi.sv
// Directed bench for clk_div_frac_multi: reset, integer and fractional division,
// glitch-free reconfiguration, rejection, disable and reset with a staged update.
module tb_clk_div_frac_multi;
  localparam int NUM_CH     = 4;
  localparam int DIV_WIDTH  = 12;
  localparam int FRAC_WIDTH = 8;

  logic clk_i = 1'b0;
  logic srst_i;
  always #5 clk_i = ~clk_i;

  clk_div_frac_multi_if #(.NUM_CH(NUM_CH), .DIV_WIDTH(DIV_WIDTH), .FRAC_WIDTH(FRAC_WIDTH)) b ();
  clk_div_frac_multi_if #(.NUM_CH(3), .DIV_WIDTH(DIV_WIDTH), .FRAC_WIDTH(FRAC_WIDTH)) b3 ();

  clk_div_frac_multi #(.NUM_CH(NUM_CH), .DIV_WIDTH(DIV_WIDTH), .FRAC_WIDTH(FRAC_WIDTH)) dut (
    .clk_i (clk_i),
    .srst_i(srst_i),
    .bus   (b)
  );

  // Three-channel instance so that an out-of-range channel index is representable.
  clk_div_frac_multi #(.NUM_CH(3), .DIV_WIDTH(DIV_WIDTH), .FRAC_WIDTH(FRAC_WIDTH)) dut3 (
    .clk_i (clk_i),
    .srst_i(srst_i),
    .bus   (b3)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int rises, first_t, r2_t, r3_t, last_t;
  logic prev;
  logic [15:0] exp_clk, exp_lk, exp_rdy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic req(input int ch, input int en, input int dint, input int dfrac);
    b.cfg_valid_i    = 1'b1;
    b.cfg_ch_i       = 2'(ch);
    b.cfg_en_i       = 1'(en);
    b.cfg_div_int_i  = 12'(dint);
    b.cfg_div_frac_i = 8'(dfrac);
    cyc();
    b.cfg_valid_i    = 1'b0;
  endtask

  initial begin
    srst_i            = 1'b1;
    b.cfg_valid_i     = 1'b0;
    b.cfg_ch_i        = '0;
    b.cfg_en_i        = 1'b0;
    b.cfg_div_int_i   = '0;
    b.cfg_div_frac_i  = '0;
    b3.cfg_valid_i    = 1'b0;
    b3.cfg_ch_i       = '0;
    b3.cfg_en_i       = 1'b0;
    b3.cfg_div_int_i  = '0;
    b3.cfg_div_frac_i = '0;

    // Reset held three cycles under random configuration traffic
    for (int i = 0; i < 3; i++) begin
      b.cfg_valid_i    = 1'($urandom);
      b.cfg_ch_i       = 2'($urandom);
      b.cfg_en_i       = 1'($urandom);
      b.cfg_div_int_i  = 12'($urandom);
      b.cfg_div_frac_i = 8'($urandom);
      cyc();
      check("rst_clk", b.clk_o, 0);
      check("rst_locked", b.locked_o, 0);
      check("rst_ready", b.cfg_ready_o, 1);
      check("rst_err", b.cfg_err_o, 0);
    end
    b.cfg_valid_i = 1'b0;
    b.cfg_ch_i    = '0;
    srst_i        = 1'b0;
    cyc();
    check("idle_err", b.cfg_err_o, 0);
    check("idle_clk", b.clk_o, 0);

    // ch0 integer divide by 4
    req(0, 1, 4, 0);
    check("ch0_pend_clk", b.clk_o[0], 0);
    check("ch0_pend_ready", b.cfg_ready_o, 0);
    exp_clk = 16'b0000_0000_0011_0011;
    exp_lk  = 16'b0000_0000_1111_0000;
    for (int i = 0; i < 8; i++) begin
      cyc();
      check("ch0_div4_clk", b.clk_o[0], exp_clk[i]);
      check("ch0_div4_lock", b.locked_o[0], exp_lk[i]);
    end

    // ch1 divide by 5: high 3 / low 2
    req(1, 1, 5, 0);
    exp_clk = 16'b0000_0000_1110_0111;
    exp_lk  = 16'b0000_0011_1110_0000;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("ch1_div5_clk", b.clk_o[1], exp_clk[i]);
      check("ch1_div5_lock", b.locked_o[1], exp_lk[i]);
    end

    // ch2 fractional 3 + 128/256: periods alternate 3,4; 256 periods = 896 cycles
    req(2, 1, 3, 128);
    rises   = 0;
    first_t = -1;
    r2_t    = -1;
    r3_t    = -1;
    last_t  = -1;
    prev    = b.clk_o[2];
    for (int t = 1; t <= 1200 && rises < 257; t++) begin
      cyc();
      if (b.clk_o[2] && !prev) begin
        rises++;
        if (rises == 1) first_t = t;
        if (rises == 2) r2_t = t;
        if (rises == 3) r3_t = t;
        last_t = t;
      end
      prev = b.clk_o[2];
    end
    check("frac_first_rise", first_t, 1);
    check("frac_period0", r2_t - first_t, 3);
    check("frac_period1", r3_t - r2_t, 4);
    check("frac_rise_count", rises, 257);
    check("frac_256_span", last_t - first_t, 896);

    // ch0 to divide by 10, then reconfigure to 4 at count 2
    req(0, 1, 10, 0);
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (b.locked_o[0]) break;
    end
    check("ch0_div10_lock", b.locked_o[0], 1);
    check("ch0_div10_rise", b.clk_o[0], 1);
    cyc();
    cyc();
    req(0, 1, 4, 0);
    check("reconf_acc_clk", b.clk_o[0], 1);
    check("reconf_acc_ready", b.cfg_ready_o, 0);
    check("reconf_acc_lock", b.locked_o[0], 0);
    exp_clk = 16'b0000_0100_1100_0001;
    exp_rdy = 16'b0000_0111_1100_0000;
    exp_lk  = 16'b0000_0100_0000_0000;
    for (int i = 0; i < 11; i++) begin
      cyc();
      check("reconf_clk", b.clk_o[0], exp_clk[i]);
      check("reconf_ready", b.cfg_ready_o, exp_rdy[i]);
      check("reconf_lock", b.locked_o[0], exp_lk[i]);
    end

    // Rejected request: enable with int=1 on ch0
    req(0, 1, 1, 0);
    check("rej_int_err", b.cfg_err_o, 1);
    check("rej_int_lock", b.locked_o[0], 1);
    check("rej_int_ready", b.cfg_ready_o, 1);
    check("rej_int_clk", b.clk_o[0], 1);
    cyc();
    check("rej_int_err_end", b.cfg_err_o, 0);
    check("rej_int_clk2", b.clk_o[0], 0);
    check("rej_int_lock2", b.locked_o[0], 1);

    // Rejected request: channel index out of range on the 3-channel instance
    b3.cfg_valid_i   = 1'b1;
    b3.cfg_ch_i      = 2'd3;
    b3.cfg_en_i      = 1'b1;
    b3.cfg_div_int_i = 12'd4;
    #1;
    check("oob_ready", b3.cfg_ready_o, 1);
    cyc();
    b3.cfg_valid_i = 1'b0;
    check("oob_err", b3.cfg_err_o, 1);
    cyc();
    check("oob_err_end", b3.cfg_err_o, 0);
    check("oob_clk", b3.clk_o, 0);
    check("oob_lock", b3.locked_o, 0);

    // Disable ch0 at the start of a high phase: the pulse must complete
    prev = b.clk_o[0];
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (b.clk_o[0] && !prev) break;
      prev = b.clk_o[0];
    end
    check("dis_sync", b.clk_o[0], 1);
    req(0, 0, 0, 0);
    check("dis_acc_clk", b.clk_o[0], 1);
    check("dis_acc_lock", b.locked_o[0], 0);
    check("dis_acc_ready", b.cfg_ready_o, 0);
    exp_rdy = 16'b0000_0000_0001_1100;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("dis_clk", b.clk_o[0], 0);
      check("dis_lock", b.locked_o[0], 0);
      check("dis_ready", b.cfg_ready_o, exp_rdy[i]);
    end

    // Reset while ch3 has a staged enable: the update must be discarded
    req(3, 1, 8, 0);
    check("rst_pend_ready", b.cfg_ready_o, 0);
    srst_i = 1'b1;
    cyc();
    check("rst_mid_clk", b.clk_o, 0);
    check("rst_mid_lock", b.locked_o, 0);
    check("rst_mid_ready", b.cfg_ready_o, 1);
    check("rst_mid_err", b.cfg_err_o, 0);
    srst_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      check("post_rst_clk", b.clk_o, 0);
      check("post_rst_lock3", b.locked_o[3], 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
